// File: rtl/wb_commit_buffer_pkg.sv
// Shared writeback types for the EU stages and the commit buffer.
// Pure declarations: no latency, no flow control.
// Debug payload fields exist only when WB_COMMIT_DEBUG_EN is defined.
package wb_commit_buffer_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;
    localparam int WB_PID_W  = 2;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        wb_entry_t   e;
`ifdef WB_COMMIT_DEBUG_EN
        logic [31:0] inst;
        logic [31:0] inst_addr;
`endif
    } wb_slot_t;

    // A write to x0 still retires, but must never reach the register file.
    function automatic logic wb_eff_we(input wb_entry_t ent);
        return ent.we & (ent.addr != '0);
    endfunction

endpackage

// File: rtl/wb_commit_slot.sv
// One pID-indexed commit slot: valid bit plus payload register.
// Set lands at the clock edge; clear (retire) and flush free the slot at the edge.
// No backpressure of its own; the owner only sets a slot that is currently empty.
module wb_commit_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_set,
    input  logic [W-1:0] i_set_dat,
    input  logic         i_clr,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_set) begin
            r_vld <= 1'b1;
            r_dat <= i_set_dat;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/wb_commit_buffer.sv
// In-order writeback commit buffer: one slot per pID, retires up to two results per cycle.
// Latency: accepted at edge T, commit outputs registered and valid after edge T+1.
// Backpressure: wayN_ready_o drops while the target slot is occupied or flush_i is high.
// Optional WB_COMMIT_DEBUG_EN carries inst/instAddr per slot through to commit.
module wb_commit_buffer
    import wb_commit_buffer_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int PID_W  = WB_PID_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,

    input  logic              way0_valid_i,
    input  logic              way0_rdWriteEnable_i,
    input  logic [ADDR_W-1:0] way0_rdAddr_i,
    input  logic [DATA_W-1:0] way0_rdData_i,
    input  logic [PID_W-1:0]  way0_pID_i,
    output logic              way0_ready_o,

    input  logic              way1_valid_i,
    input  logic              way1_rdWriteEnable_i,
    input  logic [ADDR_W-1:0] way1_rdAddr_i,
    input  logic [DATA_W-1:0] way1_rdData_i,
    input  logic [PID_W-1:0]  way1_pID_i,
    output logic              way1_ready_o,

`ifdef WB_COMMIT_DEBUG_EN
    input  logic [31:0]       way0_inst_i,
    input  logic [31:0]       way0_instAddr_i,
    input  logic [31:0]       way1_inst_i,
    input  logic [31:0]       way1_instAddr_i,
    output logic [31:0]       cmt0_inst_o,
    output logic [31:0]       cmt0_instAddr_o,
    output logic [31:0]       cmt1_inst_o,
    output logic [31:0]       cmt1_instAddr_o,
`endif

    output logic              cmt0_en_o,
    output logic              cmt0_we_o,
    output logic [ADDR_W-1:0] cmt0_addr_o,
    output logic [DATA_W-1:0] cmt0_data_o,

    output logic              cmt1_en_o,
    output logic              cmt1_we_o,
    output logic [ADDR_W-1:0] cmt1_addr_o,
    output logic [DATA_W-1:0] cmt1_data_o,

    output logic [PID_W-1:0]  head_pID_o
);

    localparam int DEPTH = 1 << PID_W;

    logic [DEPTH-1:0] w_slot_v;
    logic [DEPTH-1:0] w_slot_set;
    logic [DEPTH-1:0] w_slot_clr;
    wb_slot_t         w_slot_dat [DEPTH];
    wb_slot_t         w_set_dat  [DEPTH];

    wb_slot_t         w_in0, w_in1;
    logic             w_same_pid, w_acc0, w_acc1;
    logic [PID_W-1:0] w_head1;
    logic             w_ret0, w_ret1, w_we0, w_we1;
    wb_slot_t         w_e0, w_e1, w_out0, w_out1;

    logic [PID_W-1:0] r_head;
    logic             r_cmt0_en, r_cmt1_en;
    wb_slot_t         r_cmt0, r_cmt1;

    always_comb begin
        w_in0        = '0;
        w_in0.e.we   = way0_rdWriteEnable_i;
        w_in0.e.addr = way0_rdAddr_i;
        w_in0.e.data = way0_rdData_i;
        w_in1        = '0;
        w_in1.e.we   = way1_rdWriteEnable_i;
        w_in1.e.addr = way1_rdAddr_i;
        w_in1.e.data = way1_rdData_i;
`ifdef WB_COMMIT_DEBUG_EN
        w_in0.inst      = way0_inst_i;
        w_in0.inst_addr = way0_instAddr_i;
        w_in1.inst      = way1_inst_i;
        w_in1.inst_addr = way1_instAddr_i;
`endif
    end

    // Ready looks at pre-commit occupancy, so a slot freed this cycle reopens next cycle.
    assign w_same_pid   = way0_valid_i & (way0_pID_i == way1_pID_i);
    assign way0_ready_o = ~w_slot_v[way0_pID_i] & ~flush_i;
    assign way1_ready_o = ~w_slot_v[way1_pID_i] & ~flush_i & ~w_same_pid;
    assign w_acc0       = way0_valid_i & way0_ready_o;
    assign w_acc1       = way1_valid_i & way1_ready_o;

    assign w_head1 = r_head + PID_W'(1);
    assign w_ret0  = w_slot_v[r_head];
    assign w_ret1  = w_ret0 & w_slot_v[w_head1];
    assign w_e0    = w_slot_dat[r_head];
    assign w_e1    = w_slot_dat[w_head1];

    // On a same-rd pair only the younger (port1) write survives.
    assign w_we1 = wb_eff_we(w_e1.e);
    assign w_we0 = wb_eff_we(w_e0.e) &
                   ~(w_ret1 & w_we1 & (w_e0.e.addr == w_e1.e.addr));

    always_comb begin
        w_out0      = w_e0;
        w_out0.e.we = w_we0;
        w_out1      = w_e1;
        w_out1.e.we = w_we1;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_set[i] = (w_acc0 & (way0_pID_i == PID_W'(i))) |
                            (w_acc1 & (way1_pID_i == PID_W'(i)));
            w_set_dat[i]  = (w_acc0 & (way0_pID_i == PID_W'(i))) ? w_in0 : w_in1;
            w_slot_clr[i] = (w_ret0 & (r_head  == PID_W'(i))) |
                            (w_ret1 & (w_head1 == PID_W'(i)));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        wb_commit_slot #(.W($bits(wb_slot_t))) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_flush   (flush_i),
            .i_set     (w_slot_set[g]),
            .i_set_dat (w_set_dat[g]),
            .i_clr     (w_slot_clr[g]),
            .o_vld     (w_slot_v[g]),
            .o_dat     (w_slot_dat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            r_head    <= '0;
            r_cmt0_en <= 1'b0;
            r_cmt1_en <= 1'b0;
            r_cmt0    <= '0;
            r_cmt1    <= '0;
        end else begin
            r_head    <= r_head + PID_W'(w_ret0) + PID_W'(w_ret1);
            r_cmt0_en <= w_ret0;
            r_cmt1_en <= w_ret1;
            r_cmt0    <= w_ret0 ? w_out0 : '0;
            r_cmt1    <= w_ret1 ? w_out1 : '0;
        end
    end

    assign cmt0_en_o   = r_cmt0_en;
    assign cmt0_we_o   = r_cmt0.e.we;
    assign cmt0_addr_o = r_cmt0.e.addr;
    assign cmt0_data_o = r_cmt0.e.data;
    assign cmt1_en_o   = r_cmt1_en;
    assign cmt1_we_o   = r_cmt1.e.we;
    assign cmt1_addr_o = r_cmt1.e.addr;
    assign cmt1_data_o = r_cmt1.e.data;
    assign head_pID_o  = r_head;

`ifdef WB_COMMIT_DEBUG_EN
    assign cmt0_inst_o     = r_cmt0.inst;
    assign cmt0_instAddr_o = r_cmt0.inst_addr;
    assign cmt1_inst_o     = r_cmt1.inst;
    assign cmt1_instAddr_o = r_cmt1.inst_addr;
`endif

endmodule
